// File: rtl/shmem_pkg.sv
// shmem_pkg: types shared by the shared-memory client slice.
//   state_e   - requester FSM states
//   cmd_t     - latched command {wren, addr, data} at the arbiter's default widths
//   LAT_CNT_W - width of the read-latency counter (READ_LATENCY range 0..7)
package shmem_pkg;

  localparam int unsigned LAT_CNT_W    = 3;
  localparam int unsigned SHMEM_ADDR_W = 12;
  localparam int unsigned SHMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RDWAIT,
    RESP,
    GAP
  } state_e;

  typedef struct packed {
    logic                    wren;
    logic [SHMEM_ADDR_W-1:0] addr;
    logic [SHMEM_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/shmem_client_timer.sv
// shmem_client_timer: REQ-state watchdog for shmem_client.
//   clk, srst - clock, synchronous active-high reset
//   in_req    - FSM is in REQ this cycle
//   expired   - this is REQ cycle number TIMEOUT_CYCLES and done has not arrived
// The count restarts at 0 whenever the FSM is outside REQ; every REQ is entered
// from IDLE, so each request begins with a zero count.
module shmem_client_timer
  import shmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic in_req,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (in_req) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = in_req && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/shmem_client.sv
// shmem_client: single-port requester for the shared-memory arbiter.
// Converts a valid/ready command stream into the arbiter's request/done
// handshake, then returns read data on a valid/ready response stream.
//   cmd_*   - command in (valid/ready; wren, addr, data)
//   rsp_*   - read response out (valid/ready; data, err)
//   shmem_* - arbiter slice: request, wren, addr, datain out; dataout, done in
//   timeout - one-cycle pulse when a request is aborted by the watchdog
// Build option: define SHMEM_CLIENT_TIMEOUT_EN to add the REQ watchdog;
// otherwise REQ waits forever and timeout/rsp_err are tied low.
// ADDR_WIDTH/DATA_WIDTH are expected to match the widths in shmem_pkg.
module shmem_client
  import shmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wren,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  shmem_request,
  output logic                  shmem_wren,
  output logic [ADDR_WIDTH-1:0] shmem_addr,
  output logic [DATA_WIDTH-1:0] shmem_datain,
  input  logic [DATA_WIDTH-1:0] shmem_dataout,
  input  logic                  shmem_done,
  output logic                  timeout
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST =
    LAT_CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_e                state_q,     state_d;
  cmd_t                  cmd_q,       cmd_d;
  logic                  request_q,   request_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q,   lat_cnt_d;
  logic                  expired;
  logic                  abort;

`ifdef SHMEM_CLIENT_TIMEOUT_EN
  shmem_client_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .srst   (srst),
    .in_req (state_q == REQ),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // A real done in the same cycle wins over the watchdog.
  assign abort = expired && !shmem_done;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    lat_cnt_d   = lat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d = '{wren: cmd_wren,
                    addr: SHMEM_ADDR_W'(cmd_addr),
                    data: SHMEM_DATA_W'(cmd_data)};
          state_d = REQ;
        end
      end
      REQ: begin
        if (shmem_done) begin
          if (cmd_q.wren) begin
            state_d = GAP;
          end else if (READ_LATENCY == 0) begin
            rsp_data_d  = shmem_dataout;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            lat_cnt_d = '0;
            state_d   = RDWAIT;
          end
        end else if (abort) begin
          if (cmd_q.wren) begin
            state_d = GAP;
          end else begin
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RDWAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          rsp_data_d  = shmem_dataout;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        // Done arriving here is the arbiter's delayed copy of the last grant.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops clean.
    request_d   = (state_d == REQ);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      request_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      request_q   <= request_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

`ifdef SHMEM_CLIENT_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic timeout_q, timeout_d;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if ((state_d == RESP) && (state_q != RESP)) begin
      rsp_err_d = abort;
    end
    timeout_d = abort;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rsp_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_err = rsp_err_q;
  assign timeout = timeout_q;
`else
  assign rsp_err = 1'b0;
  assign timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign shmem_request = request_q;
  assign shmem_wren    = cmd_q.wren;
  assign shmem_addr    = ADDR_WIDTH'(cmd_q.addr);
  assign shmem_datain  = DATA_WIDTH'(cmd_q.data);

endmodule

// File: tb/tb_shmem_client.sv
// tb_shmem_client: directed bench for shmem_client (READ_LATENCY=1,
// TIMEOUT_CYCLES=8). The timeout scenario follows SHMEM_CLIENT_TIMEOUT_EN.
module tb_shmem_client;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wren = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        shmem_request;
  logic        shmem_wren;
  logic [11:0] shmem_addr;
  logic [31:0] shmem_datain;
  logic [31:0] shmem_dataout = '0;
  logic        shmem_done = 1'b0;
  logic        timeout;

  int checks = 0;
  int fails  = 0;

  shmem_client #(
    .ADDR_WIDTH    (12),
    .DATA_WIDTH    (32),
    .READ_LATENCY  (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wren     (cmd_wren),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .shmem_request(shmem_request),
    .shmem_wren   (shmem_wren),
    .shmem_addr   (shmem_addr),
    .shmem_datain (shmem_datain),
    .shmem_dataout(shmem_dataout),
    .shmem_done   (shmem_done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command in IDLE; returns in the first REQ cycle.
  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wren  = w;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_wren  = 1'b0;
    cmd_addr  = 12'hFFF;
    cmd_data  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (shmem_request !== 1'b0) begin fails++; $display("FAIL reset_request got=%b exp=0", shmem_request); end
    checks++; if (shmem_wren !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b exp=0", shmem_wren); end
    checks++; if (shmem_addr !== 12'h000) begin fails++; $display("FAIL reset_addr got=%h exp=000", shmem_addr); end
    checks++; if (shmem_datain !== 32'h0) begin fails++; $display("FAIL reset_datain got=%h exp=0", shmem_datain); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_write();
    send_cmd(1'b1, 12'h010, 32'hDEAD_BEEF);
    checks++; if (shmem_request !== 1'b1) begin fails++; $display("FAIL wr_req_c1 got=%b exp=1", shmem_request); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL wr_ready_c1 got=%b exp=0", cmd_ready); end
    checks++; if (shmem_wren !== 1'b1) begin fails++; $display("FAIL wr_wren got=%b exp=1", shmem_wren); end
    checks++; if (shmem_addr !== 12'h010) begin fails++; $display("FAIL wr_addr got=%h exp=010", shmem_addr); end
    checks++; if (shmem_datain !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_datain got=%h exp=deadbeef", shmem_datain); end
    tick();
    shmem_done = 1'b1;
    checks++; if (shmem_request !== 1'b1) begin fails++; $display("FAIL wr_req_d got=%b exp=1", shmem_request); end
    tick();
    shmem_done = 1'b0;
    checks++; if (shmem_request !== 1'b0) begin fails++; $display("FAIL wr_gap_req got=%b exp=0", shmem_request); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL wr_gap_ready got=%b exp=0", cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_d2 got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_no_rsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_read_lat1();
    send_cmd(1'b0, 12'h020, 32'h0);
    tick();
    shmem_done = 1'b1;
    tick();
    shmem_done    = 1'b0;
    shmem_dataout = 32'h1234_5678;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_d1 got=%b exp=0", rsp_valid); end
    checks++; if (shmem_request !== 1'b0) begin fails++; $display("FAIL rd_req_d1 got=%b exp=0", shmem_request); end
    tick();
    shmem_dataout = 32'h5555_AAAA;
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_valid_d2 got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h1234_5678) begin fails++; $display("FAIL rd_data got=%h exp=12345678", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rd_err got=%b exp=0", rsp_err); end
    for (int i = 0; i < 5; i++) begin
      tick();
      shmem_dataout = shmem_dataout + 32'h0101_0101;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678) begin
        fails++; $display("FAIL rd_hold[%0d] got valid=%b data=%h exp valid=1 data=12345678", i, rsp_valid, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_consumed got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rd_back_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_contention();
    int completions = 0;
    send_cmd(1'b1, 12'h3A5, 32'hA5A5_0F0F);
    for (int i = 0; i < 6; i++) begin
      cmd_addr = 12'(i * 7);
      cmd_data = 32'(i) * 32'h1111_1111;
      cmd_wren = 1'b0;
      checks++; if (shmem_request !== 1'b1 || shmem_wren !== 1'b1 || shmem_addr !== 12'h3A5 || shmem_datain !== 32'hA5A5_0F0F) begin
        fails++; $display("FAIL cont_frozen[%0d] got req=%b wren=%b addr=%h data=%h exp req=1 wren=1 addr=3a5 data=a5a50f0f",
                          i, shmem_request, shmem_wren, shmem_addr, shmem_datain);
      end
      tick();
    end
    shmem_done = 1'b1;
    checks++; if (shmem_request !== 1'b1 || shmem_addr !== 12'h3A5) begin
      fails++; $display("FAIL cont_done_cycle got req=%b addr=%h exp req=1 addr=3a5", shmem_request, shmem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      logic prev;
      prev = shmem_request;
      tick();
      shmem_done = 1'b0;
      if (prev && !shmem_request) completions++;
    end
    checks++; if (completions !== 1) begin fails++; $display("FAIL cont_completions got=%0d exp=1", completions); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cont_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_stale_done();
    send_cmd(1'b1, 12'h111, 32'h0000_0111);
    tick();
    shmem_done = 1'b1;
    tick();
    // GAP cycle: stale done plus the next command already waiting
    shmem_done = 1'b1;
    cmd_valid  = 1'b1;
    cmd_wren   = 1'b0;
    cmd_addr   = 12'h055;
    cmd_data   = 32'h0;
    checks++; if (shmem_request !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL stale_gap got req=%b ready=%b exp req=0 ready=0", shmem_request, cmd_ready);
    end
    tick();
    shmem_done = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL stale_idle got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (shmem_request !== 1'b1 || shmem_addr !== 12'h055 || shmem_wren !== 1'b0) begin
      fails++; $display("FAIL stale_next_req got req=%b addr=%h wren=%b exp req=1 addr=055 wren=0", shmem_request, shmem_addr, shmem_wren);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (shmem_request !== 1'b1 || rsp_valid !== 1'b0) begin
        fails++; $display("FAIL stale_wait[%0d] got req=%b rsp_valid=%b exp req=1 rsp_valid=0", i, shmem_request, rsp_valid);
      end
    end
    shmem_done = 1'b1;
    tick();
    shmem_done    = 1'b0;
    shmem_dataout = 32'hCAFE_F00D;
    tick();
    shmem_dataout = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL stale_rsp got valid=%b data=%h exp valid=1 data=cafef00d", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_rdwait();
    send_cmd(1'b0, 12'h066, 32'h0);
    tick();
    shmem_done = 1'b1;
    tick();
    shmem_done    = 1'b0;
    shmem_dataout = 32'h7777_7777;
    srst          = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (shmem_request !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_rdwait got req=%b rsp_valid=%b ready=%b exp req=0 rsp_valid=0 ready=1", shmem_request, rsp_valid, cmd_ready);
    end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_no_replay got=%b exp=0", rsp_valid); end
    send_cmd(1'b0, 12'h077, 32'h0);
    checks++; if (shmem_addr !== 12'h077 || shmem_request !== 1'b1) begin
      fails++; $display("FAIL rst_next_req got addr=%h req=%b exp addr=077 req=1", shmem_addr, shmem_request);
    end
    tick();
    shmem_done = 1'b1;
    tick();
    shmem_done    = 1'b0;
    shmem_dataout = 32'h0BAD_F00D;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL rst_next_rsp got valid=%b data=%h exp valid=1 data=0badf00d", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

`ifdef SHMEM_CLIENT_TIMEOUT_EN
  task automatic test_timeout();
    send_cmd(1'b0, 12'h099, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (shmem_request !== 1'b1 || timeout !== 1'b0) begin
        fails++; $display("FAIL to_req[%0d] got req=%b timeout=%b exp req=1 timeout=0", i, shmem_request, timeout);
      end
      tick();
    end
    checks++; if (timeout !== 1'b1 || shmem_request !== 1'b0) begin
      fails++; $display("FAIL to_pulse got timeout=%b req=%b exp timeout=1 req=0", timeout, shmem_request);
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      fails++; $display("FAIL to_rsp got valid=%b err=%b data=%h exp valid=1 err=1 data=0", rsp_valid, rsp_err, rsp_data);
    end
    tick();
    checks++; if (timeout !== 1'b0 || rsp_valid !== 1'b1) begin
      fails++; $display("FAIL to_single got timeout=%b valid=%b exp timeout=0 valid=1", timeout, rsp_valid);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL to_idle got=%b exp=1", cmd_ready); end
  endtask
`else
  task automatic test_timeout();
    send_cmd(1'b0, 12'h099, 32'h0);
    for (int i = 0; i < 100; i++) begin
      checks++; if (shmem_request !== 1'b1 || rsp_valid !== 1'b0 || timeout !== 1'b0 || rsp_err !== 1'b0) begin
        fails++; $display("FAIL nto_wait[%0d] got req=%b valid=%b timeout=%b err=%b exp req=1 valid=0 timeout=0 err=0",
                          i, shmem_request, rsp_valid, timeout, rsp_err);
      end
      tick();
    end
    shmem_done = 1'b1;
    tick();
    shmem_done    = 1'b0;
    shmem_dataout = 32'h0000_4242;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_4242) begin
      fails++; $display("FAIL nto_rsp got valid=%b data=%h exp valid=1 data=00004242", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_lat1();
    test_contention();
    test_stale_done();
    test_reset_rdwait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
